// File: rtl/gradient_pkg.sv
// Shared definitions for the gradient magnitude engine.
//   state_t      : FSM encoding, also exported on the debug state port
//   OP_GRAD_MAG  : the only op_code the engine executes
//   size_to_dim  : matrix_size code (0..3) -> dimension N (2..5)
//   elem_index   : row-major element slot of (r,c) on a MAX_DIM-wide bus
package gradient_pkg;

  localparam logic [2:0] OP_GRAD_MAG = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_SQ   = 3'd2,
    ST_SQRT = 3'd3,
    ST_ABS  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  function automatic logic [2:0] size_to_dim(input logic [1:0] matrix_size);
    return {1'b0, matrix_size} + 3'd2;
  endfunction

  // Buses are always packed with a MAX_DIM stride, whatever N is in use.
  function automatic int elem_index(input int r, input int c, input int max_dim);
    return r * max_dim + c;
  endfunction

endpackage

// File: rtl/gradient_magnitude_engine_isqrt_iter.sv
// isqrt_iter: iterative restoring (bit-pair) integer square root.
//   clk, reset_n : clock, async active-low reset
//   start        : 1-cycle request; radicand sampled on this edge
//   radicand     : W-bit unsigned operand
//   done         : 1-cycle pulse, root valid from this cycle until next start
//   root         : floor(sqrt(radicand)), ceil(W/2) bits
// The start edge already performs the first bit-pair step, so the root is
// final and done is high in the ceil(W/2)-th cycle after the start edge.
module isqrt_iter #(
  parameter int W = 33
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [W-1:0]         radicand,
  output logic                 done,
  output logic [(W+1)/2-1:0]   root
);

  localparam int ITER = (W + 1) / 2;
  localparam int RW   = 2 * ITER;
  localparam int CW   = $clog2(ITER + 1);

  logic [RW-1:0]   rad_q;
  logic [ITER:0]   rem_q;
  logic [ITER-1:0] root_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;

  logic [RW-1:0]   rad_in, rad_out;
  logic [ITER:0]   rem_in, rem_out;
  logic [ITER-1:0] root_in, root_out;
  logic [ITER+3:0] trial;

  // One step: bring down the next bit pair and try subtracting (4*root+1).
  always_comb begin
    if (start) begin
      rad_in  = RW'(radicand);
      rem_in  = '0;
      root_in = '0;
    end else begin
      rad_in  = rad_q;
      rem_in  = rem_q;
      root_in = root_q;
    end
    trial   = {1'b0, rem_in, rad_in[RW-1 -: 2]} - {2'b00, root_in, 2'b01};
    rad_out = {rad_in[RW-3:0], 2'b00};
    if (!trial[ITER+3]) begin
      rem_out  = trial[ITER:0];
      root_out = {root_in[ITER-2:0], 1'b1};
    end else begin
      rem_out  = {rem_in[ITER-2:0], rad_in[RW-1 -: 2]};
      root_out = {root_in[ITER-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rad_q  <= rad_out;
        rem_q  <= rem_out;
        root_q <= root_out;
        cnt_q  <= CW'(ITER - 1);
      end else if (cnt_q != '0) begin
        rad_q  <= rad_out;
        rem_q  <= rem_out;
        root_q <= root_out;
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign root = root_q;

endmodule

// File: rtl/gradient_magnitude_engine.sv
// gradient_magnitude_engine: sequential Sobel-style gradient magnitude unit.
//   clk, reset_n        : clock, async active-low reset
//   start, op_code      : request and operation (3'b111 only legal)
//   matrix_size         : 0..3 -> N = 2..5, top-left NxN of each bus used
//   matrix_a/kernel_x/y : MAX_DIM*MAX_DIM signed elements, row-major
//   busy, done, error   : status; done/error are 1-cycle pulses
//   saturated, result   : clamp flag and magnitude, held until next accept
//   dbg_state           : current FSM state
// Handshake: start is only sampled in IDLE; that edge is the accept, busy is
// high from it until DONE is left, done (and error for an illegal op) pulse
// for the single DONE cycle, and a new start is accepted in the IDLE cycle
// after DONE at the earliest. Nothing is queued while busy.
// Build option: define GRAD_L1_APPROX_EN to replace the exact square root
// with |Gx|+|Gy| (one ABS state, no isqrt_iter instance).
module gradient_magnitude_engine
  import gradient_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [2:0]                        op_code,
  input  logic [1:0]                        matrix_size,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_a,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] kernel_x,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] kernel_y,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              saturated,
  output logic [OUT_W-1:0]                  result,
  output logic [2:0]                        dbg_state
);

  localparam int BUS_W = MAX_DIM * MAX_DIM * ELEM_W;

  state_t state_q, state_d;

  logic [BUS_W-1:0]        a_q, kx_q, ky_q;
  logic [2:0]              dim_q, row_q, col_q;
  logic                    illegal_q;
  logic signed [ACC_W-1:0] gx_q, gy_q;
  logic                    acc_sat_q;
  logic [OUT_W-1:0]        result_q;
  logic                    sat_q;

  logic                      accept, mac_last, load_out;
  int                        elem_idx;
  logic signed [ELEM_W-1:0]  a_el, kx_el, ky_el;
  logic signed [2*ELEM_W-1:0] prod_x, prod_y;
  logic [ACC_W:0]            sum_x, sum_y;
  logic                      ovf_x, ovf_y;
  logic [ACC_W+1:0]          r_val;
  logic                      out_ovf;

  // Clamp an (ACC_W+1)-bit sum back into the signed ACC_W range.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
    if (s[ACC_W] == s[ACC_W-1]) return s[ACC_W-1:0];
    else if (!s[ACC_W])         return {1'b0, {(ACC_W-1){1'b1}}};
    else                        return {1'b1, {(ACC_W-1){1'b0}}};
  endfunction

  // Datapath: current element products and saturating sums.
  always_comb begin
    elem_idx = elem_index(int'(row_q), int'(col_q), MAX_DIM);
    a_el     = a_q[elem_idx*ELEM_W +: ELEM_W];
    kx_el    = kx_q[elem_idx*ELEM_W +: ELEM_W];
    ky_el    = ky_q[elem_idx*ELEM_W +: ELEM_W];
    prod_x   = a_el * kx_el;
    prod_y   = a_el * ky_el;
    sum_x    = {gx_q[ACC_W-1], gx_q} + {{(ACC_W+1-2*ELEM_W){prod_x[2*ELEM_W-1]}}, prod_x};
    sum_y    = {gy_q[ACC_W-1], gy_q} + {{(ACC_W+1-2*ELEM_W){prod_y[2*ELEM_W-1]}}, prod_y};
    ovf_x    = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    ovf_y    = sum_y[ACC_W] ^ sum_y[ACC_W-1];
    mac_last = (row_q == dim_q - 3'd1) && (col_q == dim_q - 3'd1);
  end

`ifdef GRAD_L1_APPROX_EN
  logic [ACC_W:0] abs_x, abs_y;

  // |x| is taken in ACC_W+1 bits so the most negative value maps correctly;
  // the sum gets one more bit since both terms can reach 2^(ACC_W-1).
  always_comb begin
    abs_x = gx_q[ACC_W-1] ? -{gx_q[ACC_W-1], gx_q} : {1'b0, gx_q};
    abs_y = gy_q[ACC_W-1] ? -{gy_q[ACC_W-1], gy_q} : {1'b0, gy_q};
    r_val = {1'b0, abs_x} + {1'b0, abs_y};
  end
`else
  logic signed [2*ACC_W-1:0] gx_sq, gy_sq;
  logic [2*ACC_W:0]          s_val;
  logic                      sq_start, sq_done;
  logic [ACC_W:0]            sq_root;

  always_comb begin
    gx_sq = gx_q * gx_q;
    gy_sq = gy_q * gy_q;
    // Both squares are non-negative, so zero extension is exact.
    s_val = {1'b0, gx_sq} + {1'b0, gy_sq};
    r_val = {1'b0, sq_root};
  end

  isqrt_iter #(.W(2*ACC_W+1)) u_isqrt (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (sq_start),
    .radicand (s_val),
    .done     (sq_done),
    .root     (sq_root)
  );
`endif

  assign out_ovf = |r_val[ACC_W+1:OUT_W];
  assign accept  = (state_q == ST_IDLE) && start;

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
`ifndef GRAD_L1_APPROX_EN
    sq_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (start) state_d = (op_code == OP_GRAD_MAG) ? ST_MAC : ST_DONE;
`ifdef GRAD_L1_APPROX_EN
      ST_MAC:  if (mac_last) state_d = ST_ABS;
      ST_ABS: begin
        state_d  = ST_DONE;
        load_out = 1'b1;
      end
`else
      ST_MAC:  if (mac_last) state_d = ST_SQ;
      ST_SQ: begin
        sq_start = 1'b1;
        state_d  = ST_SQRT;
      end
      ST_SQRT: if (sq_done) begin
        state_d  = ST_DONE;
        load_out = 1'b1;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      dim_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      illegal_q <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      acc_sat_q <= 1'b0;
      result_q  <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q       <= matrix_a;
        kx_q      <= kernel_x;
        ky_q      <= kernel_y;
        dim_q     <= size_to_dim(matrix_size);
        illegal_q <= (op_code != OP_GRAD_MAG);
        row_q     <= '0;
        col_q     <= '0;
        gx_q      <= '0;
        gy_q      <= '0;
        acc_sat_q <= 1'b0;
        result_q  <= '0;
        sat_q     <= 1'b0;
      end else if (state_q == ST_MAC) begin
        gx_q      <= sat_acc(sum_x);
        gy_q      <= sat_acc(sum_y);
        acc_sat_q <= acc_sat_q | ovf_x | ovf_y;
        if (col_q == dim_q - 3'd1) begin
          col_q <= '0;
          row_q <= row_q + 3'd1;
        end else begin
          col_q <= col_q + 3'd1;
        end
      end
      // Result is registered on the edge into DONE so it is valid with done.
      if (load_out) begin
        result_q <= out_ovf ? {OUT_W{1'b1}} : r_val[OUT_W-1:0];
        sat_q    <= acc_sat_q | out_ovf;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_DONE) && illegal_q;
  assign saturated = sat_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
